// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package inst_fetch_pkg;

   localparam int ADDR_W       = 32;
   localparam int RST_VEC_ADDR = 0;
   localparam int INT_VEC_ADDR = RST_VEC_ADDR + 2;
   localparam int LONG_BIT     = 15;

   typedef enum logic [1:0] {
      VEC = 2'd0,
      RUN = 2'd1,
      INT = 2'd2
   } fetch_state_t;

   // Memory words arrive as {M[a+1], M[a]}; vectors and long instructions want M[a] on top.
   function automatic logic [31:0] swap_halves(input logic [31:0] w);
      return {w[15:0], w[31:16]};
   endfunction

endpackage

// File: rtl/inst_fetch_if_buffer.sv
// rtl/inst_fetch_if_buffer.sv - one-entry registered valid/ready buffer with flush
module inst_fetch_if_buffer #(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   // Flush wins over a load; the payload is left alone so it never changes while valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC, reset vector load, 16/32-bit length decode; optional FETCH_INT_EN interrupt entry
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W       = inst_fetch_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(inst_fetch_pkg::RST_VEC_ADDR),
   parameter int                LONG_BIT     = inst_fetch_pkg::LONG_BIT
)(
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_INT_EN
   input  logic              int_req,
   output logic              int_ack,
   output logic [ADDR_W-1:0] int_ret_pc,
`endif
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_long
);

   localparam int BUF_W = 33 + ADDR_W;

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [ADDR_W-1:0] vec_pc;
   logic              is_long;
   logic [31:0]       instr_new;
   logic              load, flush, buf_ready;
   logic [BUF_W-1:0]  buf_in, buf_out;
`ifdef FETCH_INT_EN
   localparam logic [ADDR_W-1:0] INT_VEC_ADDR = RST_VEC_ADDR + ADDR_W'(2);
   logic              take_int;
`endif

   assign vec_pc    = ADDR_W'(swap_halves(mem_data));
   assign is_long   = mem_data[LONG_BIT];
   assign instr_new = is_long ? swap_halves(mem_data) : {16'h0000, mem_data[15:0]};

   always_comb begin
      state_next = state;
      pc_next    = pc;
      mem_addr   = pc;
      load       = 1'b0;
      flush      = 1'b0;
`ifdef FETCH_INT_EN
      take_int   = 1'b0;
      int_ack    = 1'b0;
`endif
      case (state)
         VEC: begin
            // Redirects are ignored here: the vector always lands first.
            mem_addr   = RST_VEC_ADDR;
            pc_next    = vec_pc;
            state_next = RUN;
         end
         RUN: begin
            if (redirect_en) begin
               pc_next = redirect_pc;
               flush   = 1'b1;
`ifdef FETCH_INT_EN
            end else if (int_req) begin
               take_int   = 1'b1;
               flush      = 1'b1;
               state_next = INT;
`endif
            end else if (buf_ready) begin
               load    = 1'b1;
               pc_next = pc + (is_long ? ADDR_W'(2) : ADDR_W'(1));
            end
         end
`ifdef FETCH_INT_EN
         INT: begin
            mem_addr   = INT_VEC_ADDR;
            pc_next    = vec_pc;
            int_ack    = 1'b1;
            state_next = RUN;
         end
`endif
         default: state_next = VEC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= VEC;
         pc    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

`ifdef FETCH_INT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         int_ret_pc <= '0;
      else if (take_int)
         int_ret_pc <= pc;
   end
`endif

   assign buf_in = {is_long, pc, instr_new};

   inst_fetch_if_buffer #(
      .DATA_W(BUF_W)
   ) u_if_buffer (
      .clk      (clk),
      .rst      (rst),
      .in_valid (load),
      .in_data  (buf_in),
      .in_ready (buf_ready),
      .flush    (flush),
      .out_valid(if_valid),
      .out_ready(if_ready),
      .out_data (buf_out)
   );

   assign {if_long, if_pc, if_instr} = buf_out;

endmodule
